// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accelerator register block:
// word offsets, CTRL/STATUS bit positions, job FSM encoding, byte-merge helper.
package conv_pkg;

    localparam int LEN_W_DEF = 16;

    // Word offsets, compared against addr[7:2]
    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_SRC    = 6'h02;
    localparam logic [5:0] OFF_DST    = 6'h03;
    localparam logic [5:0] OFF_LEN    = 6'h04;
    localparam logic [5:0] OFF_CYCLES = 6'h05;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } conv_state_e;

    function automatic logic [31:0] apply_wmask(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wmask);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_icb_rsp_buf.sv
// Single-entry ICB response register: captures rdata/err when a command is
// accepted and holds them until the master takes the response.
module conv_icb_rsp_buf (
    input  logic        hfclk,
    input  logic        corerst,
    input  logic        load,
    input  logic [31:0] rdata_in,
    input  logic        err_in,
    input  logic        rsp_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (load) begin
            valid_d = 1'b1;
            rdata_d = rdata_in;
            err_d   = err_in;
        end else if (valid_q && rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge hfclk) begin
        if (corerst) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: rtl/conv_icb_regs.sv
// ICB slave register block for the convolution engine: address decode, job
// FSM, cycle counter and level interrupt. Responses live in conv_icb_rsp_buf.
import conv_pkg::*;

module conv_icb_regs #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              hfclk,
    input  logic              corerst,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ADDR_W-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [31:0]       icb_cmd_wdata,
    input  logic [3:0]        icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [31:0]       icb_rsp_rdata,
    output logic              icb_rsp_err,
    output logic              conv_start,
    output logic [31:0]       conv_src_addr,
    output logic [31:0]       conv_dst_addr,
    output logic [LEN_W-1:0]  conv_len,
    input  logic              conv_done,
    output logic              conv_irq
);

    // state | meaning
    // IDLE  | no job; descriptor writable, conv_done ignored
    // RUN   | job launched; CYCLES counting, waiting for conv_done

    conv_state_e      state_q, state_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      cycles_q, cycles_d;
    logic             start_q, start_d;
    logic             irq_q, irq_d;

    logic        busy, cmd_acc, cmd_wr, start_req, err_cmd, wr_ok;
    logic [5:0]  off;
    logic [31:0] rdata_cmd, len_rd;
    logic        rsp_valid;
    logic        unused_addr;

    assign unused_addr   = ^{icb_cmd_addr[ADDR_W-1:8], icb_cmd_addr[1:0]};
    assign icb_cmd_ready = ~rsp_valid;
    assign icb_rsp_valid = rsp_valid;

    // Decode: error and read data are computed for every command; only an
    // accepted command loads them into the response buffer.
    always_comb begin
        off       = icb_cmd_addr[7:2];
        busy      = (state_q == ST_RUN);
        cmd_acc   = icb_cmd_valid & icb_cmd_ready;
        cmd_wr    = cmd_acc & ~icb_cmd_read;
        start_req = cmd_wr && (off == OFF_CTRL) && icb_cmd_wmask[0]
                    && icb_cmd_wdata[CTRL_START];
        len_rd    = '0;
        len_rd[LEN_W-1:0] = len_q;
        err_cmd   = 1'b0;
        rdata_cmd = '0;
        case (off)
            OFF_CTRL: begin
                err_cmd                = start_req & busy;
                rdata_cmd[CTRL_IRQ_EN] = irq_en_q;
            end
            OFF_STATUS: begin
                rdata_cmd[STATUS_BUSY] = busy;
                rdata_cmd[STATUS_DONE] = done_q;
            end
            OFF_SRC: begin
                err_cmd   = cmd_wr & busy;
                rdata_cmd = src_q;
            end
            OFF_DST: begin
                err_cmd   = cmd_wr & busy;
                rdata_cmd = dst_q;
            end
            OFF_LEN: begin
                err_cmd   = cmd_wr & busy;
                rdata_cmd = len_rd;
            end
            OFF_CYCLES: begin
                err_cmd   = cmd_wr;
                rdata_cmd = cycles_q;
            end
            default: err_cmd = 1'b1;
        endcase
        if (err_cmd || !icb_cmd_read) rdata_cmd = '0;
        wr_ok = cmd_wr & ~err_cmd;
    end

    always_comb begin
        state_d  = state_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        cycles_d = cycles_q;
        start_d  = 1'b0;
        irq_d    = done_q & irq_en_q;
        if (wr_ok) begin
            case (off)
                OFF_CTRL: begin
                    if (icb_cmd_wmask[0]) begin
                        irq_en_d = icb_cmd_wdata[CTRL_IRQ_EN];
                        if (icb_cmd_wdata[CTRL_START]) begin
                            state_d  = ST_RUN;
                            cycles_d = '0;
                            done_d   = 1'b0;
                            start_d  = 1'b1;
                        end
                    end
                end
                OFF_STATUS: begin
                    if (icb_cmd_wmask[0] && icb_cmd_wdata[STATUS_DONE]) done_d = 1'b0;
                end
                OFF_SRC: src_d = apply_wmask(src_q, icb_cmd_wdata, icb_cmd_wmask);
                OFF_DST: dst_d = apply_wmask(dst_q, icb_cmd_wdata, icb_cmd_wmask);
                OFF_LEN: len_d = LEN_W'(apply_wmask(len_rd, icb_cmd_wdata, icb_cmd_wmask));
                default: ;
            endcase
        end
        // Completion is applied after the W1C so a same-edge done wins.
        if (busy) begin
            if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
            if (conv_done) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge hfclk) begin
        if (corerst) begin
            state_q  <= ST_IDLE;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            cycles_q <= '0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            cycles_q <= cycles_d;
            start_q  <= start_d;
            irq_q    <= irq_d;
        end
    end

    conv_icb_rsp_buf u_rsp_buf (
        .hfclk     (hfclk),
        .corerst   (corerst),
        .load      (cmd_acc),
        .rdata_in  (rdata_cmd),
        .err_in    (err_cmd),
        .rsp_ready (icb_rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (icb_rsp_rdata),
        .rsp_err   (icb_rsp_err)
    );

    assign conv_start    = start_q;
    assign conv_src_addr = src_q;
    assign conv_dst_addr = dst_q;
    assign conv_len      = len_q;
    assign conv_irq      = irq_q;

endmodule

// File: tb/tb_conv_icb_regs.sv
// Self-checking bench for conv_icb_regs: randomized register traffic and jobs
// checked against a transaction-level model of the register map.
module tb_conv_icb_regs;

    logic        hfclk = 1'b0;
    logic        corerst = 1'b1;
    logic        icb_cmd_valid = 1'b0;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr = '0;
    logic        icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_wdata = '0;
    logic [3:0]  icb_cmd_wmask = '0;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready = 1'b1;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        conv_start;
    logic [31:0] conv_src_addr;
    logic [31:0] conv_dst_addr;
    logic [15:0] conv_len;
    logic        conv_done = 1'b0;
    logic        conv_irq;

    conv_icb_regs #(.ADDR_W(32), .LEN_W(16)) dut (
        .hfclk         (hfclk),
        .corerst       (corerst),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .conv_start    (conv_start),
        .conv_src_addr (conv_src_addr),
        .conv_dst_addr (conv_dst_addr),
        .conv_len      (conv_len),
        .conv_done     (conv_done),
        .conv_irq      (conv_irq)
    );

    always #5 hfclk = ~hfclk;

    int cyc = 0;
    int start_pulses = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge hfclk) cyc <= cyc + 1;
    always @(negedge hfclk) if (conv_start === 1'b1) start_pulses++;

    // Reference model: register contents and job bookkeeping
    logic [31:0] m_src, m_dst, m_cycles;
    logic [15:0] m_len;
    bit          m_irq_en, m_done, m_busy;
    int          m_start_cyc;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] e_rdata;
        logic        e_err;
        bit          ok;
        logic        start_s;
        logic        irq_s;
    } xr_t;

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd, input logic [3:0] mk);
        logic [31:0] v = cur;
        for (int i = 0; i < 4; i++) if (mk[i]) v[8*i +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    function automatic bit model_err(input bit rd, input int off, input logic [31:0] wd, input logic [3:0] mk);
        if (off > 5) return 1'b1;
        if (rd) return 1'b0;
        if (off == 0) return mk[0] && wd[0] && m_busy;
        if (off >= 2 && off <= 4) return m_busy;
        if (off == 5) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_rdata(input bit rd, input int off, input int acc);
        if (!rd || off > 5) return 32'h0;
        case (off)
            0: return m_irq_en ? 32'h2 : 32'h0;
            1: return (m_done ? 32'h2 : 32'h0) | (m_busy ? 32'h1 : 32'h0);
            2: return m_src;
            3: return m_dst;
            4: return {16'h0, m_len};
            default: return m_busy ? 32'(acc - m_start_cyc - 1) : m_cycles;
        endcase
    endfunction

    task automatic model_update(input bit rd, input int off, input logic [31:0] wd, input logic [3:0] mk,
                                input bit pd, input int acc, input bit err);
        logic [31:0] t;
        bit pre_busy = m_busy;
        if (!rd && !err) begin
            case (off)
                0: if (mk[0]) begin
                    m_irq_en = wd[1];
                    if (wd[0]) begin
                        m_busy = 1; m_done = 0; m_cycles = 0; m_start_cyc = acc;
                    end
                end
                1: if (mk[0] && wd[1]) m_done = 0;
                2: m_src = merge(m_src, wd, mk);
                3: m_dst = merge(m_dst, wd, mk);
                4: begin t = merge({16'h0, m_len}, wd, mk); m_len = t[15:0]; end
                default: ;
            endcase
        end
        if (pre_busy && pd) begin
            m_busy = 0; m_done = 1; m_cycles = 32'(acc - m_start_cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge hfclk);
        corerst = 1'b1; icb_cmd_valid = 1'b0; conv_done = 1'b0; icb_rsp_ready = 1'b1;
        repeat (2) @(negedge hfclk);
        corerst = 1'b0;
        m_src = 0; m_dst = 0; m_len = 0; m_cycles = 0;
        m_irq_en = 0; m_done = 0; m_busy = 0; m_start_cyc = 0;
    endtask

    // One ICB transaction with rsp_ready high; optionally pulses conv_done on the accept edge.
    task automatic xact(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] mk, input bit pd, output xr_t r);
        int n = 0;
        int acc, off;
        r.ok = 1'b1;
        @(negedge hfclk);
        while (icb_cmd_ready !== 1'b1 && n < 20) begin @(negedge hfclk); n++; end
        if (icb_cmd_ready !== 1'b1) r.ok = 1'b0;
        off = int'(addr[7:2]);
        acc = cyc;
        r.e_err   = model_err(rd, off, wd, mk);
        r.e_rdata = r.e_err ? 32'h0 : model_rdata(rd, off, acc);
        icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
        icb_cmd_wdata = wd; icb_cmd_wmask = mk; conv_done = pd;
        @(posedge hfclk); #1;
        icb_cmd_valid = 1'b0; conv_done = 1'b0;
        model_update(rd, off, wd, mk, pd, acc, r.e_err);
        @(negedge hfclk);
        r.rdata = icb_rsp_rdata; r.err = icb_rsp_err;
        r.start_s = conv_start; r.irq_s = conv_irq;
        if (icb_rsp_valid !== 1'b1) r.ok = 1'b0;
        @(posedge hfclk); #1;
    endtask

    task automatic pulse_done_at(input int target, output bit ok);
        int n = 0;
        int at;
        @(negedge hfclk);
        while (cyc < target && n < 5000) begin @(negedge hfclk); n++; end
        ok = (cyc == target);
        at = cyc;
        conv_done = 1'b1;
        @(posedge hfclk); #1;
        conv_done = 1'b0;
        if (m_busy) begin m_busy = 0; m_done = 1; m_cycles = 32'(at - m_start_cyc); end
    endtask

    task automatic test_reset();
        xr_t r;
        logic [31:0] alist [3] = '{32'h04, 32'h08, 32'h14};
        do_reset();
        n_cmp++;
        if (icb_cmd_ready !== 1'b1 || icb_rsp_valid !== 1'b0 || conv_start !== 1'b0 || conv_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: ready=%b rsp_valid=%b start=%b irq=%b want 1 0 0 0",
                     icb_cmd_ready, icb_rsp_valid, conv_start, conv_irq);
        end
        n_cmp++;
        if (conv_src_addr !== 32'h0 || conv_dst_addr !== 32'h0 || conv_len !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_desc: src=%h dst=%h len=%h want 0", conv_src_addr, conv_dst_addr, conv_len);
        end
        foreach (alist[i]) begin
            xact(1'b1, alist[i], 32'h0, 4'h0, 1'b0, r);
            n_cmp++;
            if (!r.ok || r.rdata !== 32'h0 || r.err !== 1'b0 || conv_irq !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_read %h: ok=%0b rdata=%h err=%b irq=%b want 0 0 0", alist[i], r.ok, r.rdata, r.err, conv_irq);
            end
        end
    endtask

    task automatic test_random_regs();
        xr_t r;
        logic [31:0] addr, wd;
        int off;
        bit rd;
        for (int k = 0; k < 48; k++) begin
            off  = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 63) : $urandom_range(0, 5);
            addr = $urandom;
            addr[7:2] = 6'(off);
            wd   = $urandom;
            if (off == 0) wd[0] = 1'b0;
            rd   = $urandom_range(0, 1) == 1;
            xact(rd, addr, wd, 4'($urandom), 1'b0, r);
            n_cmp++;
            if (!r.ok || r.err !== r.e_err || r.rdata !== r.e_rdata || conv_irq !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_reg off=%0d rd=%0b: ok=%0b err=%b/%b rdata=%h/%h irq=%b",
                         off, rd, r.ok, r.err, r.e_err, r.rdata, r.e_rdata, conv_irq);
            end
        end
        n_cmp++;
        if (conv_src_addr !== m_src || conv_dst_addr !== m_dst || conv_len !== m_len) begin
            n_bad++;
            $display("FAIL rnd_desc: src=%h/%h dst=%h/%h len=%h/%h", conv_src_addr, m_src,
                     conv_dst_addr, m_dst, conv_len, m_len);
        end
    endtask

    task automatic run_job(input string nm, input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input bit ien, input int k);
        xr_t r;
        bit ok;
        int p0;
        xact(1'b0, 32'h08, src, 4'hF, 1'b0, r);
        xact(1'b0, 32'h0C, dst, 4'hF, 1'b0, r);
        xact(1'b0, 32'h10, {16'h0, len}, 4'hF, 1'b0, r);
        p0 = start_pulses;
        xact(1'b0, 32'h00, {30'h0, ien, 1'b1}, 4'h1, 1'b0, r);
        n_cmp++;
        if (!r.ok || r.err !== 1'b0 || r.start_s !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_start: ok=%0b err=%b start=%b want err 0 start 1", nm, r.ok, r.err, r.start_s);
        end
        xact(1'b1, 32'h04, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.rdata !== 32'h1 || r.rdata !== r.e_rdata || conv_src_addr !== src || conv_dst_addr !== dst || conv_len !== len) begin
            n_bad++;
            $display("FAIL %s_busy: status=%h want 1 src=%h dst=%h len=%h", nm, r.rdata, conv_src_addr, conv_dst_addr, conv_len);
        end
        pulse_done_at(m_start_cyc + k, ok);
        @(negedge hfclk);
        n_cmp++;
        if (!ok || conv_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_irq_early: ok=%0b irq=%b want 0", nm, ok, conv_irq);
        end
        @(negedge hfclk);
        n_cmp++;
        if (conv_irq !== ien) begin
            n_bad++;
            $display("FAIL %s_irq: irq=%b want %b", nm, conv_irq, ien);
        end
        xact(1'b1, 32'h04, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (!r.ok || r.rdata !== 32'h2 || r.err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_status: ok=%0b rdata=%h err=%b want 2 0", nm, r.ok, r.rdata, r.err);
        end
        xact(1'b1, 32'h14, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (!r.ok || r.rdata !== 32'(k) || r.rdata !== r.e_rdata || r.err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_cycles: ok=%0b rdata=%0d want %0d", nm, r.ok, r.rdata, k);
        end
        n_cmp++;
        if (start_pulses - p0 !== 1) begin
            n_bad++;
            $display("FAIL %s_start_count: got %0d want 1", nm, start_pulses - p0);
        end
    endtask

    task automatic test_job();
        run_job("job", 32'h8000_1000, 32'h9000_0000, 16'h0040, 1'b1, 100);
    endtask

    task automatic test_irq_disable();
        xr_t r;
        xact(1'b0, 32'h00, 32'h0, 4'h1, 1'b0, r);
        n_cmp++;
        if (!r.ok || r.irq_s !== 1'b1 || conv_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_drop: ok=%0b irq_at_rsp=%b irq_after=%b want 1 0", r.ok, r.irq_s, conv_irq);
        end
        xact(1'b0, 32'h00, 32'h2, 4'hE, 1'b0, r);
        xact(1'b1, 32'h00, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.rdata !== 32'h0 || r.rdata !== r.e_rdata || conv_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL ctrl_nobyte0: ctrl=%h irq=%b want 0 0", r.rdata, conv_irq);
        end
        xact(1'b0, 32'h00, 32'h2, 4'h1, 1'b0, r);
        n_cmp++;
        if (conv_irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_reenable: irq=%b want 1", conv_irq);
        end
        xact(1'b0, 32'h04, 32'h2, 4'h1, 1'b0, r);
        xact(1'b1, 32'h04, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.rdata !== 32'h0 || r.err !== 1'b0 || conv_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL done_w1c: status=%h err=%b irq=%b want 0 0 0", r.rdata, r.err, conv_irq);
        end
    endtask

    task automatic test_done_collision();
        xr_t r;
        xact(1'b0, 32'h00, 32'h3, 4'h1, 1'b0, r);
        repeat ($urandom_range(2, 10)) @(negedge hfclk);
        xact(1'b0, 32'h04, 32'h2, 4'h1, 1'b1, r);
        n_cmp++;
        if (!r.ok || r.err !== 1'b0 || conv_irq !== 1'b1) begin
            n_bad++;
            $display("FAIL coll_w1c: ok=%0b err=%b irq=%b want 0 1", r.ok, r.err, conv_irq);
        end
        xact(1'b1, 32'h04, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.rdata !== 32'h2 || conv_irq !== 1'b1) begin
            n_bad++;
            $display("FAIL coll_status: status=%h irq=%b want 2 1", r.rdata, conv_irq);
        end
        xact(1'b1, 32'h14, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.rdata !== r.e_rdata) begin
            n_bad++;
            $display("FAIL coll_cycles: got %0d want %0d", r.rdata, r.e_rdata);
        end
    endtask

    task automatic test_run_errors();
        xr_t r;
        int p0;
        logic [31:0] src0;
        xact(1'b0, 32'h08, $urandom, 4'hF, 1'b0, r);
        src0 = m_src;
        p0 = start_pulses;
        xact(1'b0, 32'h00, 32'h1, 4'h1, 1'b0, r);
        xact(1'b0, 32'h00, 32'h1, 4'h1, 1'b0, r);
        n_cmp++;
        if (!r.ok || r.err !== 1'b1 || r.rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL run_restart: ok=%0b err=%b rdata=%h want 1 0", r.ok, r.err, r.rdata);
        end
        xact(1'b0, 32'h08, 32'h1234, 4'hF, 1'b0, r);
        n_cmp++;
        if (r.err !== 1'b1 || conv_src_addr !== src0) begin
            n_bad++;
            $display("FAIL run_src_wr: err=%b src=%h want 1 %h", r.err, conv_src_addr, src0);
        end
        xact(1'b0, 32'h0C, $urandom, 4'($urandom_range(1, 15)), 1'b0, r);
        n_cmp++;
        if (r.err !== r.e_err || r.err !== 1'b1) begin
            n_bad++;
            $display("FAIL run_dst_wr: err=%b want 1", r.err);
        end
        xact(1'b0, 32'h10, $urandom, 4'($urandom_range(1, 15)), 1'b0, r);
        n_cmp++;
        if (r.err !== 1'b1 || conv_len !== m_len) begin
            n_bad++;
            $display("FAIL run_len_wr: err=%b len=%h want 1 %h", r.err, conv_len, m_len);
        end
        xact(1'b1, 32'h08, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.err !== 1'b0 || r.rdata !== src0) begin
            n_bad++;
            $display("FAIL run_src_rd: err=%b rdata=%h want 0 %h", r.err, r.rdata, src0);
        end
        xact(1'b1, 32'h14, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.err !== 1'b0 || r.rdata !== r.e_rdata) begin
            n_bad++;
            $display("FAIL run_cycles_rd: rdata=%0d want %0d", r.rdata, r.e_rdata);
        end
        xact(1'b0, 32'h00, 32'h1, 4'h1, 1'b1, r);
        n_cmp++;
        if (r.err !== 1'b1 || r.start_s !== 1'b0) begin
            n_bad++;
            $display("FAIL start_done_same: err=%b start=%b want 1 0", r.err, r.start_s);
        end
        xact(1'b1, 32'h04, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.rdata !== 32'h2 || start_pulses - p0 !== 1) begin
            n_bad++;
            $display("FAIL run_end: status=%h want 2 starts=%0d want 1", r.rdata, start_pulses - p0);
        end
    endtask

    task automatic test_errors_backpressure();
        xr_t r;
        logic [31:0] want;
        xact(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.err !== 1'b1 || r.rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL unmapped_rd: err=%b rdata=%h want 1 0", r.err, r.rdata);
        end
        xact(1'b0, 32'h14, $urandom, 4'hF, 1'b0, r);
        n_cmp++;
        if (r.err !== 1'b1 || r.rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL cycles_wr: err=%b rdata=%h want 1 0", r.err, r.rdata);
        end
        xact(1'b0, 32'h08, $urandom | 32'h1, 4'hF, 1'b0, r);
        want = m_src;
        @(negedge hfclk);
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h08; icb_cmd_wmask = 4'h0;
        @(posedge hfclk); #1;
        icb_cmd_addr = 32'h04;
        for (int i = 0; i < 5; i++) begin
            @(negedge hfclk);
            n_cmp++;
            if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== want || icb_rsp_err !== 1'b0 || icb_cmd_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d]: valid=%b rdata=%h/%h err=%b ready=%b", i, icb_rsp_valid,
                         icb_rsp_rdata, want, icb_rsp_err, icb_cmd_ready);
            end
        end
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = 1'b1;
        @(posedge hfclk); #1;
        @(negedge hfclk);
        n_cmp++;
        if (icb_rsp_valid !== 1'b0 || icb_cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_release: valid=%b ready=%b want 0 1", icb_rsp_valid, icb_cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            run_job("b2b", $urandom, $urandom, 16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(12, 80));
        end
    endtask

    task automatic test_reset_midjob();
        xr_t r;
        xact(1'b0, 32'h08, $urandom | 32'h100, 4'hF, 1'b0, r);
        xact(1'b0, 32'h00, 32'h3, 4'h1, 1'b0, r);
        repeat (6) @(negedge hfclk);
        do_reset();
        xact(1'b1, 32'h04, 32'h0, 4'h0, 1'b1, r);
        n_cmp++;
        if (!r.ok || r.rdata !== 32'h0 || r.err !== 1'b0 || conv_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_status: status=%h err=%b irq=%b want 0 0 0", r.rdata, r.err, conv_irq);
        end
        xact(1'b1, 32'h14, 32'h0, 4'h0, 1'b0, r);
        n_cmp++;
        if (r.rdata !== 32'h0 || conv_src_addr !== 32'h0 || conv_start !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_regs: cycles=%h src=%h start=%b want 0", r.rdata, conv_src_addr, conv_start);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_random_regs();
        test_job();
        test_irq_disable();
        test_done_collision();
        test_run_errors();
        test_errors_backpressure();
        test_back_to_back();
        test_reset_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_icb_regs.md
# conv_icb_regs

ICB slave register block for the convolution accelerator, on the peripheral ICB bus of the E203 subsystem. Firmware running from ITCM programs the job descriptor, launches the engine, and polls or takes the interrupt. The block drives the start and descriptor to the conv ICB master engine, consumes its done pulse, and produces the level-sensitive `conv_irq` that the platform and bench monitor.

## Interface

Parameters:
- `ADDR_W`, default 32: ICB address width.
- `LEN_W`, default 16: width of the job length field.

Ports:
- `hfclk` in 1: the single clock.
- `corerst` in 1: reset, synchronous and active-high.
- `icb_cmd_valid` in 1: command valid.
- `icb_cmd_ready` out 1: command ready.
- `icb_cmd_addr` in ADDR_W: byte address. Only bits [7:2] are decoded.
- `icb_cmd_read` in 1: 1 = read, 0 = write.
- `icb_cmd_wdata` in 32: write data.
- `icb_cmd_wmask` in 4: byte enables.
- `icb_rsp_valid` out 1: response valid.
- `icb_rsp_ready` in 1: response ready.
- `icb_rsp_rdata` out 32: read data.
- `icb_rsp_err` out 1: error flag.
- `conv_start` out 1: one-cycle launch pulse.
- `conv_src_addr` out 32: source descriptor.
- `conv_dst_addr` out 32: destination descriptor.
- `conv_len` out LEN_W: job length.
- `conv_done` in 1: one-cycle completion pulse from the engine.
- `conv_irq` out 1: registered interrupt, `done & irq_en`.

## Operation

Register map (offset from addr[7:0]):
- 0x00 CTRL: bit0 START (write-1, self-clearing, reads 0); bit1 IRQ_EN (RW).
- 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear).
- 0x08 SRC_ADDR: RW, 32 bits.
- 0x0C DST_ADDR: RW, 32 bits.
- 0x10 LEN: RW, LEN_W bits. Upper bits read 0.
- 0x14 CYCLES: RO. Cycles spent in RUN during the last job.

Write and mask rules:
- `wmask` applies per byte to RW registers.
- CTRL and STATUS act only when byte 0 is enabled.

FSM: IDLE, RUN.
- IDLE → RUN on an accepted write to CTRL with START=1. This also clears CYCLES and DONE. `conv_start` pulses on the next cycle.
- RUN → IDLE on `conv_done`. DONE is set on the same edge.
- BUSY = (state == RUN).

CYCLES:
- Increments each cycle in RUN.
- Saturates at 0xFFFF_FFFF.
- Holds its value in IDLE.

Error responses (`rsp_err=1`, `rdata=0`, no state change):
- Unmapped offset (0x18–0xFC).
- START write while in RUN.
- Write to SRC, DST or LEN while in RUN.
- Write to CYCLES.

Simultaneous events and boundaries:
- `conv_done` and a DONE W1C on the same edge: set wins, DONE=1.
- `conv_done` while IDLE: ignored.
- START and `conv_done` on the same edge while in RUN: START is rejected with err; the FSM goes to IDLE.
- Write with IRQ_EN=0 while DONE=1: `conv_irq` drops on the next cycle.
- Reset mid-job: everything returns to reset values. A later `conv_done` is ignored because the FSM is in IDLE.

Reset values: all registers 0, state IDLE, `icb_cmd_ready=1`, `icb_rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `conv_start=0`, `conv_irq=0`, descriptor outputs 0.

## Timing

- At most one outstanding transaction. `icb_cmd_ready = ~icb_rsp_valid`.
- Command accepted on `valid & ready` at edge N. `rsp_valid` is asserted at N+1 and held, with `rdata`/`err` stable, until `rsp_ready`.
- The register update from a write is visible at N+1.
- `conv_start` is high exactly at N+1 for a START accepted at edge N.
- Descriptor outputs are direct register outputs, stable for the whole job.
- `conv_irq` is registered: it rises one cycle after DONE sets, provided IRQ_EN=1.

## Structure

- Shared package `conv_pkg` holds:
  - register offset constants;
  - CTRL/STATUS bit indices;
  - FSM state encoding;
  - `LEN_W` default.
- One sub-module is natural: `conv_icb_rsp_buf`, the single-entry response holding register plus valid/ready logic.
- Decode and the FSM stay in the top module.

## Test plan

- Reset, then read 0x04, 0x08 and 0x14 → all `rdata=0`, `err=0`, `conv_irq=0`.
- Write SRC=0x8000_1000, DST=0x9000_0000, LEN=0x0040, CTRL=0x3; engine pulses done 100 cycles later → single `conv_start` pulse; BUSY=1 during the job; then STATUS=0x2, CYCLES=100, `conv_irq=1` one cycle after done.
- Write 0x2 to STATUS with `conv_done` on the same edge → DONE stays 1 and `conv_irq` stays high.
- During RUN, write CTRL=0x1 and SRC=0x1234 → both give `err=1`; SRC unchanged; exactly one `conv_start` pulse total.
- Read 0x20 and write 0x14 → `err=1`, `rdata=0`. Hold `rsp_ready` low for 5 cycles → `rsp_valid`/`rdata` held stable and `cmd_ready=0` throughout.
- Assert `corerst` mid-job, then pulse `conv_done` → BUSY=0, DONE=0, `conv_irq=0`, no state change.
